// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - binary-to-BCD converter with 4-digit multiplexed seven-segment scan
// Double-dabble FSM loads a display buffer; an independent refresh divider drives anode/segment pins.
module display_scan_controller #(
    parameter int REFRESH_DIV = 257,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              blank_en,
    output logic              busy,
    output logic [3:0]        an,
    output logic [6:0]        seg
);

    localparam int          CNT_W    = $clog2(DATA_W);
    localparam int          BCD_W    = 20;
    localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic [15:0]        upper;
    logic [3:0]         nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add-3 correction applied before each shift so every nibble stays a valid BCD digit.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = {adj[BCD_W-2:0], shreg_q[DATA_W-1]};
                shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = scratch_q[15:0];
                ovf_d   = |scratch_q[BCD_W-1:16];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // seg is built from the index about to be shown so an and seg stay aligned.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
        idx_d = (div_q == DIV_LAST) ? idx_q + 2'd1 : idx_q;
        an_d  = ~(4'b0001 << idx_d);
        upper = disp_q >> {idx_d, 2'b00};
        nib   = disp_q[{idx_d, 2'b00} +: 4];
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank_en && (idx_d != 2'd0) && (upper == 16'd0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            div_q     <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign an       = an_q;
    assign seg      = seg_q;

endmodule
